// File: rtl/divmod_unit_if.sv
// Command/result bundle for divmod_unit: the CPU side drives the command,
// the divider returns the result, its status and the handshake.
interface divmod_unit_if #(
    parameter int WIDTH = 32
);
    logic             enable;
    logic             unsgn_or_sgn;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] denom;
    logic             flush;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             div_by_zero;
    logic             can_accept_cmd;
    logic             data_ready;

    modport master (
        output enable, unsgn_or_sgn, num, denom, flush,
        input  quot, rem, div_by_zero, can_accept_cmd, data_ready
    );

    modport slave (
        input  enable, unsgn_or_sgn, num, denom, flush,
        output quot, rem, div_by_zero, can_accept_cmd, data_ready
    );
endinterface

// File: rtl/divmod_unit.sv
// Iterative restoring divider on operand magnitudes, retiring BITS_PER_CYCLE
// quotient bits per cycle; signs are applied in a single FIXUP cycle.
module divmod_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    divmod_unit_if.slave bus
);
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] prem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] div_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             num_neg_reg;
    logic             den_neg_reg;
    logic             zero_reg;
    logic [WIDTH-1:0] quot_reg;
    logic [WIDTH-1:0] rem_reg;
    logic             dbz_reg;
    logic             ready_reg;

    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] num_mag;
    logic [WIDTH-1:0] den_mag;
    logic [WIDTH:0]   prem_work;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] fix_quot;
    logic [WIDTH-1:0] fix_rem;

    assign can_accept = (state_reg == IDLE) || (state_reg == DONE);
    assign accept     = can_accept && bus.enable && !bus.flush;
    assign num_mag    = (bus.unsgn_or_sgn && bus.num[WIDTH-1])   ? -bus.num   : bus.num;
    assign den_mag    = (bus.unsgn_or_sgn && bus.denom[WIDTH-1]) ? -bus.denom : bus.denom;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = (bus.denom == '0) ? FIXUP : ITER;
                end
            end
            ITER: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (cnt_reg == CNT_W'(1)) begin
                    state_next = FIXUP;
                end
            end
            FIXUP:   state_next = bus.flush ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    // The dividend shifts out of quo_reg MSB first while quotient bits shift in.
    always_comb begin
        prem_work = {1'b0, prem_reg};
        quo_next  = quo_reg;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            prem_work = {prem_work[WIDTH-1:0], quo_next[WIDTH-1]};
            quo_next  = {quo_next[WIDTH-2:0], 1'b0};
            if (prem_work >= {1'b0, div_reg}) begin
                prem_work   = prem_work - {1'b0, div_reg};
                quo_next[0] = 1'b1;
            end
        end
    end

    // With a zero divisor no iteration ran, so quo_reg still holds |num|.
    always_comb begin
        fix_quot = quo_reg;
        fix_rem  = prem_reg;
        if (zero_reg) begin
            fix_quot = '1;
            fix_rem  = num_neg_reg ? -quo_reg : quo_reg;
        end else begin
            if (num_neg_reg ^ den_neg_reg) begin
                fix_quot = -quo_reg;
            end
            if (num_neg_reg) begin
                fix_rem = -prem_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prem_reg    <= '0;
            quo_reg     <= '0;
            div_reg     <= '0;
            cnt_reg     <= '0;
            num_neg_reg <= 1'b0;
            den_neg_reg <= 1'b0;
            zero_reg    <= 1'b0;
            quot_reg    <= '0;
            rem_reg     <= '0;
            dbz_reg     <= 1'b0;
            ready_reg   <= 1'b0;
        end else begin
            if (accept) begin
                prem_reg    <= '0;
                quo_reg     <= num_mag;
                div_reg     <= den_mag;
                cnt_reg     <= CNT_W'(N);
                num_neg_reg <= bus.unsgn_or_sgn && bus.num[WIDTH-1];
                den_neg_reg <= bus.unsgn_or_sgn && bus.denom[WIDTH-1];
                zero_reg    <= (bus.denom == '0);
            end else if (state_reg == ITER) begin
                prem_reg <= prem_work[WIDTH-1:0];
                quo_reg  <= quo_next;
                cnt_reg  <= cnt_reg - CNT_W'(1);
            end
            ready_reg <= (state_reg == FIXUP) && !bus.flush;
            if ((state_reg == FIXUP) && !bus.flush) begin
                quot_reg <= fix_quot;
                rem_reg  <= fix_rem;
                dbz_reg  <= zero_reg;
            end
        end
    end

    assign bus.quot           = quot_reg;
    assign bus.rem            = rem_reg;
    assign bus.div_by_zero    = dbz_reg;
    assign bus.data_ready     = ready_reg;
    assign bus.can_accept_cmd = can_accept;
endmodule

// File: tb/tb_divmod_unit.sv
// Scoreboard bench for divmod_unit: a 32-bit/1-bit-per-cycle and a
// 64-bit/4-bit-per-cycle instance checked against a native-arithmetic model.
module tb_divmod_unit;
    localparam int NA = 32;
    localparam int NB = 16;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   rdy_a = 0;
    int   rdy_b = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t got_a, got_b, last_a;

    divmod_unit_if #(.WIDTH(32)) ia ();
    divmod_unit_if #(.WIDTH(64)) ib ();

    divmod_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    divmod_unit #(.WIDTH(64), .BITS_PER_CYCLE(4)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int w, input bit sgn, input logic [63:0] a_in, input logic [63:0] b_in);
        exp_t               e;
        logic [63:0]        mask, a, b;
        logic signed [63:0] sa, sb, tq, tr;
        mask  = (w == 64) ? {64{1'b1}} : {32'h0, {32{1'b1}}};
        a     = a_in & mask;
        b     = b_in & mask;
        e.acc = 0;
        e.lat = 0;
        e.dz  = 1'b0;
        if (b == 64'd0) begin
            e.q  = mask;
            e.r  = a;
            e.dz = 1'b1;
        end else if (sgn) begin
            sa = (w == 64) ? signed'(a) : signed'({{32{a[31]}}, a[31:0]});
            sb = (w == 64) ? signed'(b) : signed'({{32{b[31]}}, b[31:0]});
            if (sb == -64'sd1) begin
                tq = -sa;
                tr = 64'sd0;
            end else begin
                tq = sa / sb;
                tr = sa % sb;
            end
            e.q = tq & mask;
            e.r = tr & mask;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input bit sel, input bit sgn, input logic [63:0] a, input logic [63:0] b, input bit keep);
        int   guard = 0;
        exp_t e;
        while (!(sel ? ib.can_accept_cmd : ia.can_accept_cmd) && guard < 500) begin
            tick(1);
            guard++;
        end
        if (guard >= 500) check("accept_wait", sel ? ib.can_accept_cmd : ia.can_accept_cmd, 1);
        e     = model(sel ? 64 : 32, sgn, a, b);
        e.acc = cyc;
        e.lat = e.dz ? 2 : (sel ? NB : NA) + 2;
        if (sel) begin
            ib.enable = 1'b1; ib.unsgn_or_sgn = sgn; ib.num = a; ib.denom = b;
        end else begin
            ia.enable = 1'b1; ia.unsgn_or_sgn = sgn; ia.num = a[31:0]; ia.denom = b[31:0];
        end
        tick(1);
        ia.enable = 1'b0;
        ib.enable = 1'b0;
        if (keep) begin
            if (sel) sb_b.push_back(e);
            else     sb_a.push_back(e);
        end
    endtask

    task automatic drain(input bit sel);
        int guard = 0;
        while ((sel ? sb_b.size() : sb_a.size()) != 0 && guard < 2000) begin
            tick(1);
            guard++;
        end
        if (guard >= 2000) check("drain_timeout", sel ? sb_b.size() : sb_a.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && ia.data_ready) begin
            rdy_a++;
            if (sb_a.size() == 0) begin
                check("a_unexpected_ready", ia.data_ready, 0);
            end else begin
                got_a = sb_a.pop_front();
                $display("A txn quot=%h rem=%h dbz=%b cycles=%0d", ia.quot, ia.rem, ia.div_by_zero, cyc - got_a.acc);
                check("a_quot", ia.quot, got_a.q);
                check("a_rem", ia.rem, got_a.r);
                check("a_dbz", ia.div_by_zero, got_a.dz);
                check("a_latency", cyc - got_a.acc, got_a.lat);
                last_a = got_a;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ib.data_ready) begin
            rdy_b++;
            if (sb_b.size() == 0) begin
                check("b_unexpected_ready", ib.data_ready, 0);
            end else begin
                got_b = sb_b.pop_front();
                $display("B txn quot=%h rem=%h dbz=%b cycles=%0d", ib.quot, ib.rem, ib.div_by_zero, cyc - got_b.acc);
                check("b_quot", ib.quot, got_b.q);
                check("b_rem", ib.rem, got_b.r);
                check("b_dbz", ib.div_by_zero, got_b.dz);
                check("b_latency", cyc - got_b.acc, got_b.lat);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r0;
        int          g;
        bit          sgn;
        logic [63:0] a, b;
        ia.enable = 1'b0; ia.unsgn_or_sgn = 1'b0; ia.num = '0; ia.denom = '0; ia.flush = 1'b0;
        ib.enable = 1'b0; ib.unsgn_or_sgn = 1'b0; ib.num = '0; ib.denom = '0; ib.flush = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check("a_rst_quot", ia.quot, 0);
        check("a_rst_rem", ia.rem, 0);
        check("a_rst_dbz", ia.div_by_zero, 0);
        check("a_rst_ready", ia.data_ready, 0);
        check("a_rst_accept", ia.can_accept_cmd, 1);
        check("b_rst_quot", ib.quot, 0);
        check("b_rst_accept", ib.can_accept_cmd, 1);

        // Unsigned 100/7 with busy window
        issue(0, 0, 64'd100, 64'd7, 1);
        for (int m = 1; m <= NA + 1; m++) begin
            check("a_busy", ia.can_accept_cmd, 0);
            tick(1);
        end
        check("a_accept_after_done", ia.can_accept_cmd, 1);
        drain(0);

        // Signed cases, overflow, signed and unsigned divide-by-zero
        issue(0, 1, 64'hFFFF_FFF9, 64'd2, 1);
        issue(0, 1, 64'd7, 64'hFFFF_FFFE, 1);
        issue(0, 1, 64'h8000_0000, 64'hFFFF_FFFF, 1);
        issue(0, 1, 64'hFFFF_FFFB, 64'd0, 1);
        issue(0, 0, 64'd5, 64'd0, 1);
        issue(0, 0, 64'd6, 64'd3, 1);
        drain(0);

        // Enable during ITER is ignored
        r0 = rdy_a;
        issue(0, 0, 64'd200, 64'd9, 1);
        tick(2);
        ia.enable = 1'b1; ia.num = 32'd50; ia.denom = 32'd5;
        tick(1);
        ia.enable = 1'b0;
        drain(0);
        tick(NA + 4);
        check("a_iter_enable_pulses", rdy_a - r0, 1);

        // Flush at ITER cycle 5
        issue(0, 0, 64'd1000, 64'd3, 0);
        tick(4);
        ia.flush = 1'b1;
        tick(1);
        ia.flush = 1'b0;
        check("a_flush_idle", ia.can_accept_cmd, 1);
        r0 = rdy_a;
        tick(NA + 4);
        check("a_flush_no_ready", rdy_a - r0, 0);
        check("a_flush_quot", ia.quot, last_a.q);
        check("a_flush_rem", ia.rem, last_a.r);
        check("a_flush_dbz", ia.div_by_zero, last_a.dz);

        // Back-to-back: new command in the data_ready cycle
        r0 = rdy_a;
        issue(0, 0, 64'd77, 64'd5, 1);
        g = 0;
        while (!ia.data_ready && g < 100) begin
            tick(1);
            g++;
        end
        if (g >= 100) check("a_b2b_ready_wait", ia.data_ready, 1);
        issue(0, 0, 64'd81, 64'd4, 1);
        tick(10);
        check("a_hold_quot", ia.quot, 15);
        check("a_hold_rem", ia.rem, 2);
        drain(0);
        tick(2);
        check("a_b2b_pulses", rdy_a - r0, 2);

        // Flush together with enable while idle: dropped
        ia.enable = 1'b1; ia.flush = 1'b1; ia.num = 32'd9; ia.denom = 32'd3;
        tick(1);
        ia.enable = 1'b0; ia.flush = 1'b0;
        check("a_flush_blocks_cmd", ia.can_accept_cmd, 1);
        r0 = rdy_a;
        tick(NA + 4);
        check("a_blocked_no_ready", rdy_a - r0, 0);
        check("a_blocked_quot", ia.quot, last_a.q);

        // Reset at ITER cycle 5
        issue(0, 0, 64'd1000, 64'd3, 0);
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("a_midrst_quot", ia.quot, 0);
        check("a_midrst_rem", ia.rem, 0);
        check("a_midrst_dbz", ia.div_by_zero, 0);
        check("a_midrst_ready", ia.data_ready, 0);
        check("a_midrst_accept", ia.can_accept_cmd, 1);
        r0 = rdy_a;
        tick(NA + 4);
        check("a_midrst_no_ready", rdy_a - r0, 0);

        // Random operands on the 32-bit instance
        for (int i = 0; i < 200; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = {32'h0, $urandom};
            b   = ($urandom_range(0, 7) == 0) ? 64'd0 : {32'h0, $urandom >> $urandom_range(0, 31)};
            issue(0, sgn, a, b, 1);
        end
        drain(0);

        // 64-bit, 4 bits per cycle
        issue(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1);
        drain(1);
        for (int i = 0; i < 1000; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 7) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0:       b = 64'd0;
                1:       b = 64'hFFFF_FFFF_FFFF_FFFF;
                2:       b = 64'($urandom_range(1, 15));
                3:       b = {32'h0, $urandom};
                default: b = {$urandom, $urandom};
            endcase
            issue(1, sgn, a, b, 1);
        end
        drain(1);
        tick(2);
        check("a_sb_empty", sb_a.size(), 0);
        check("b_sb_empty", sb_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
